master_port: RTL and testbench

Bus-side master port for the serial system bus. It converts a parallel request from a master device into the bit-serial protocol that slave ports consume:
- requests the bus from the arbiter;
- shifts out address and write data LSB-first with `mvalid`;
- for reads, collects the serial read data returned under `svalid`.

It sits between a master device and the arbiter/bus mux, directly upstream of each `slave_port`. It also handles split reads and read timeouts.

---
 rtl/master_port.sv | 216 +++++++++++++++++++++
 tb/tb_master_port.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// Serial-bus master port: arbitrates for the bus, shifts address/write data
// out LSB-first and reassembles serial read data, with split and timeout handling.
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  drvalid,
  output logic                  derror,
  output logic                  mbreq,
  input  logic                  mbgrant,
  input  logic                  msplit,
  input  logic                  sready,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  mrdata,
  input  logic                  svalid
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WDATA, S_WAITR, S_SPLIT, S_RDATA
  } state_t;

  typedef struct packed {
    logic                  mode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  localparam logic [7:0] ALAST  = 8'(ADDR_WIDTH - 1);
  localparam logic [7:0] DLAST  = 8'(DATA_WIDTH - 1);
  localparam logic [7:0] DLAST1 = 8'(DATA_WIDTH - 2);
  localparam logic [7:0] TMO    = 8'(TIMEOUT);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            tmo_q, tmo_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic                  drvalid_q, drvalid_d;
  logic                  derror_q, derror_d;
  logic                  mbreq_q, mbreq_d;
  logic                  mvalid_q, mvalid_d;
  logic                  mwdata_q, mwdata_d;
  logic                  mmode_q, mmode_d;
  logic [DATA_WIDTH-1:0] rbuf_in;

  // Read bits enter at the MSB and walk down, so bit 0 lands last at [0].
  generate
    if (DATA_WIDTH == 1) begin : g_rin1
      assign rbuf_in = mrdata;
    end else begin : g_rinn
      assign rbuf_in = {mrdata, rbuf_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    req_d     = req_q;
    rbuf_d    = rbuf_q;
    drdata_d  = drdata_q;
    drvalid_d = 1'b0;
    derror_d  = 1'b0;
    mbreq_d   = mbreq_q;
    mvalid_d  = mvalid_q;
    mwdata_d  = mwdata_q;
    mmode_d   = mmode_q;

    case (state_q)
      S_IDLE: begin
        if (dvalid) begin
          req_d.mode  = dmode;
          req_d.addr  = daddr;
          req_d.wdata = dwdata;
          mbreq_d     = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (mbgrant && sready) begin
          mvalid_d   = 1'b1;
          mwdata_d   = req_q.addr[0];
          mmode_d    = req_q.mode;
          req_d.addr = req_q.addr >> 1;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == ALAST) begin
          if (req_q.mode) begin
            mwdata_d    = req_q.wdata[0];
            req_d.wdata = req_q.wdata >> 1;
            state_d     = S_WDATA;
          end else begin
            mvalid_d = 1'b0;
            tmo_d    = 8'd0;
            state_d  = S_WAITR;
          end
        end else begin
          cnt_d      = cnt_q + 8'd1;
          mwdata_d   = req_q.addr[0];
          req_d.addr = req_q.addr >> 1;
        end
      end
      S_WDATA: begin
        if (cnt_q == DLAST) begin
          mvalid_d = 1'b0;
          mbreq_d  = 1'b0;
          state_d  = S_IDLE;
        end else begin
          cnt_d       = cnt_q + 8'd1;
          mwdata_d    = req_q.wdata[0];
          req_d.wdata = req_q.wdata >> 1;
        end
      end
      S_WAITR: begin
        if (svalid) begin
          rbuf_d = rbuf_in;
          if (DATA_WIDTH == 1) begin
            drdata_d  = rbuf_in;
            drvalid_d = 1'b1;
            mbreq_d   = 1'b0;
            state_d   = S_IDLE;
          end else begin
            state_d = S_RDATA;
          end
        end else if (msplit) begin
          state_d = S_SPLIT;
        end else if (tmo_q == TMO) begin
          derror_d = 1'b1;
          mbreq_d  = 1'b0;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_SPLIT: begin
        // Timeout count is held here so split time is not charged to the slave.
        if (mbgrant && !msplit) state_d = S_WAITR;
      end
      S_RDATA: begin
        // cnt counts bits received after the first, captured back in WAITR.
        if (svalid) begin
          rbuf_d = rbuf_in;
          if (cnt_q == DLAST1) begin
            drdata_d  = rbuf_in;
            drvalid_d = 1'b1;
            mbreq_d   = 1'b0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        mbreq_d  = 1'b0;
        mvalid_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      tmo_q     <= 8'd0;
      req_q     <= '0;
      rbuf_q    <= '0;
      drdata_q  <= '0;
      drvalid_q <= 1'b0;
      derror_q  <= 1'b0;
      mbreq_q   <= 1'b0;
      mvalid_q  <= 1'b0;
      mwdata_q  <= 1'b0;
      mmode_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      req_q     <= req_d;
      rbuf_q    <= rbuf_d;
      drdata_q  <= drdata_d;
      drvalid_q <= drvalid_d;
      derror_q  <= derror_d;
      mbreq_q   <= mbreq_d;
      mvalid_q  <= mvalid_d;
      mwdata_q  <= mwdata_d;
      mmode_q   <= mmode_d;
    end
  end

  assign dready  = (state_q == S_IDLE);
  assign drdata  = drdata_q;
  assign drvalid = drvalid_q;
  assign derror  = derror_q;
  assign mbreq   = mbreq_q;
  assign mvalid  = mvalid_q;
  assign mwdata  = mwdata_q;
  assign mmode   = mmode_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: write, read, gapped read, split, timeout,
// async reset mid-transaction and grant-without-sready.
module tb_master_port;
  logic        clk, rstn;
  logic        dvalid, dmode;
  logic [11:0] daddr;
  logic [7:0]  dwdata;
  logic        dready;
  logic [7:0]  drdata;
  logic        drvalid, derror, mbreq;
  logic        mbgrant, msplit, sready;
  logic        mwdata, mmode, mvalid;
  logic        mrdata, svalid;

  int errors = 0;
  int checks = 0;

  master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .TIMEOUT(10)) dut (
    .clk(clk), .rstn(rstn),
    .dvalid(dvalid), .dmode(dmode), .daddr(daddr), .dwdata(dwdata),
    .dready(dready), .drdata(drdata), .drvalid(drvalid), .derror(derror),
    .mbreq(mbreq), .mbgrant(mbgrant), .msplit(msplit), .sready(sready),
    .mwdata(mwdata), .mmode(mmode), .mvalid(mvalid),
    .mrdata(mrdata), .svalid(svalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a read and runs it through the address phase; returns in the first WAITR cycle.
  task automatic start_read(input logic [11:0] a);
    dvalid = 1'b1; dmode = 1'b0; daddr = a;
    tick();
    dvalid = 1'b0;
    mbgrant = 1'b1; sready = 1'b1;
    tick();
    repeat (12) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    for (int i = 0; i < 8; i++) begin
      svalid = 1'b1; mrdata = d[i];
      tick();
      if (gap > 0 && i < 7) begin
        svalid = 1'b0; mrdata = 1'b1;
        repeat (gap) tick();
      end
    end
    svalid = 1'b0; mrdata = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    dvalid = 0; dmode = 0; daddr = '0; dwdata = '0;
    mbgrant = 0; msplit = 0; sready = 0; mrdata = 0; svalid = 0;
    #22;
    checks++; if (mbreq !== 1'b0)   begin errors++; $display("FAIL reset_mbreq got=%b exp=0", mbreq); end
    checks++; if (mvalid !== 1'b0)  begin errors++; $display("FAIL reset_mvalid got=%b exp=0", mvalid); end
    checks++; if (mwdata !== 1'b0)  begin errors++; $display("FAIL reset_mwdata got=%b exp=0", mwdata); end
    checks++; if (mmode !== 1'b0)   begin errors++; $display("FAIL reset_mmode got=%b exp=0", mmode); end
    checks++; if (drdata !== 8'h00) begin errors++; $display("FAIL reset_drdata got=%h exp=00", drdata); end
    checks++; if (drvalid !== 1'b0) begin errors++; $display("FAIL reset_drvalid got=%b exp=0", drvalid); end
    checks++; if (derror !== 1'b0)  begin errors++; $display("FAIL reset_derror got=%b exp=0", derror); end
    checks++; if (dready !== 1'b1)  begin errors++; $display("FAIL reset_dready got=%b exp=1", dready); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    logic [19:0] exp_bits;
    exp_bits = {8'h3E, 12'hA5C};
    dvalid = 1'b1; dmode = 1'b1; daddr = 12'hA5C; dwdata = 8'h3E;
    tick();
    dvalid = 1'b0;
    checks++; if (mbreq !== 1'b1)  begin errors++; $display("FAIL wr_mbreq got=%b exp=1", mbreq); end
    checks++; if (dready !== 1'b0) begin errors++; $display("FAIL wr_dready_busy got=%b exp=0", dready); end
    tick(); tick();
    checks++; if (mvalid !== 1'b0) begin errors++; $display("FAIL wr_no_grant_mvalid got=%b exp=0", mvalid); end
    mbgrant = 1'b1; sready = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (mvalid !== 1'b1 || mwdata !== exp_bits[i] || mmode !== 1'b1) begin
        errors++;
        $display("FAIL wr_bit%0d got mvalid=%b mwdata=%b mmode=%b exp 1 %b 1", i, mvalid, mwdata, mmode, exp_bits[i]);
      end
      tick();
    end
    checks++; if (mvalid !== 1'b0) begin errors++; $display("FAIL wr_end_mvalid got=%b exp=0", mvalid); end
    checks++; if (dready !== 1'b1) begin errors++; $display("FAIL wr_end_dready got=%b exp=1", dready); end
    checks++; if (mbreq !== 1'b0)  begin errors++; $display("FAIL wr_end_mbreq got=%b exp=0", mbreq); end
  endtask

  task automatic test_read();
    logic [11:0] a;
    a = 12'h123;
    dvalid = 1'b1; dmode = 1'b0; daddr = a;
    tick();
    dvalid = 1'b0;
    mbgrant = 1'b1; sready = 1'b1;
    svalid = 1'b1; mrdata = 1'b1;  // stray slave data during REQ/ADDR must be ignored
    tick();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (mvalid !== 1'b1 || mwdata !== a[i] || mmode !== 1'b0) begin
        errors++;
        $display("FAIL rd_addr%0d got mvalid=%b mwdata=%b mmode=%b exp 1 %b 0", i, mvalid, mwdata, mmode, a[i]);
      end
      tick();
    end
    svalid = 1'b0; mrdata = 1'b0;
    checks++; if (mvalid !== 1'b0) begin errors++; $display("FAIL rd_waitr_mvalid got=%b exp=0", mvalid); end
    checks++; if (mbreq !== 1'b1)  begin errors++; $display("FAIL rd_waitr_mbreq got=%b exp=1", mbreq); end
    repeat (3) tick();
    send_byte(8'hB7, 0);
    checks++; if (drvalid !== 1'b1) begin errors++; $display("FAIL rd_drvalid got=%b exp=1", drvalid); end
    checks++; if (drdata !== 8'hB7) begin errors++; $display("FAIL rd_drdata got=%h exp=b7", drdata); end
    checks++; if (mbreq !== 1'b0)   begin errors++; $display("FAIL rd_mbreq got=%b exp=0", mbreq); end
    checks++; if (dready !== 1'b1)  begin errors++; $display("FAIL rd_dready got=%b exp=1", dready); end
    tick();
    checks++; if (drvalid !== 1'b0) begin errors++; $display("FAIL rd_drvalid_pulse got=%b exp=0", drvalid); end
    checks++; if (drdata !== 8'hB7) begin errors++; $display("FAIL rd_drdata_hold got=%h exp=b7", drdata); end
  endtask

  task automatic test_gaps();
    start_read(12'h0F0);
    send_byte(8'h5A, 2);
    checks++; if (drvalid !== 1'b1) begin errors++; $display("FAIL gap_drvalid got=%b exp=1", drvalid); end
    checks++; if (drdata !== 8'h5A) begin errors++; $display("FAIL gap_drdata got=%h exp=5a", drdata); end
    tick();
    checks++; if (drvalid !== 1'b0) begin errors++; $display("FAIL gap_extra_pulse got=%b exp=0", drvalid); end
  endtask

  task automatic test_split();
    int seen_err;
    seen_err = 0;
    start_read(12'h456);
    tick(); tick();
    msplit = 1'b1; mbgrant = 1'b0;
    repeat (20) begin
      tick();
      if (derror === 1'b1) seen_err++;
    end
    checks++; if (mbreq !== 1'b1) begin errors++; $display("FAIL split_mbreq got=%b exp=1", mbreq); end
    msplit = 1'b0; mbgrant = 1'b1;
    tick();
    if (derror === 1'b1) seen_err++;
    send_byte(8'hC3, 0);
    checks++; if (seen_err !== 0)   begin errors++; $display("FAIL split_derror got=%0d exp=0", seen_err); end
    checks++; if (drvalid !== 1'b1) begin errors++; $display("FAIL split_drvalid got=%b exp=1", drvalid); end
    checks++; if (drdata !== 8'hC3) begin errors++; $display("FAIL split_drdata got=%h exp=c3", drdata); end
    tick();
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    start_read(12'h789);
    if (derror === 1'b1) early++;
    repeat (10) begin
      tick();
      if (derror === 1'b1) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early got=%0d exp=0", early); end
    tick();
    checks++; if (derror !== 1'b1)  begin errors++; $display("FAIL tmo_derror got=%b exp=1", derror); end
    checks++; if (mbreq !== 1'b0)   begin errors++; $display("FAIL tmo_mbreq got=%b exp=0", mbreq); end
    checks++; if (dready !== 1'b1)  begin errors++; $display("FAIL tmo_dready got=%b exp=1", dready); end
    checks++; if (drvalid !== 1'b0) begin errors++; $display("FAIL tmo_drvalid got=%b exp=0", drvalid); end
    checks++; if (drdata !== 8'hC3) begin errors++; $display("FAIL tmo_drdata got=%h exp=c3", drdata); end
    tick();
    checks++; if (derror !== 1'b0)  begin errors++; $display("FAIL tmo_pulse got=%b exp=0", derror); end
    dvalid = 1'b1; dmode = 1'b1; daddr = 12'h01E; dwdata = 8'hFF;
    mbgrant = 1'b0; sready = 1'b0;
    tick();
    dvalid = 1'b0;
    checks++; if (mbreq !== 1'b1) begin errors++; $display("FAIL tmo_next_accept got=%b exp=1", mbreq); end
  endtask

  // Continues the write accepted at the end of test_timeout.
  task automatic test_ignored_and_reset();
    int stray;
    stray = 0;
    mbgrant = 1'b1; sready = 1'b0;
    repeat (3) begin
      tick();
      if (mvalid !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL nosready_mvalid got=%0d exp=0", stray); end
    sready = 1'b1;
    tick();
    checks++; if (mvalid !== 1'b1 || mwdata !== 1'b0) begin errors++; $display("FAIL sready_bit0 got mvalid=%b mwdata=%b exp 1 0", mvalid, mwdata); end
    mbgrant = 1'b0;  // grant drop mid-shift is ignored
    repeat (4) tick();
    checks++; if (mvalid !== 1'b1 || mwdata !== 1'b1 || mmode !== 1'b1) begin errors++; $display("FAIL bit4 got mvalid=%b mwdata=%b mmode=%b exp 1 1 1", mvalid, mwdata, mmode); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (mvalid !== 1'b0)  begin errors++; $display("FAIL arst_mvalid got=%b exp=0", mvalid); end
    checks++; if (mbreq !== 1'b0)   begin errors++; $display("FAIL arst_mbreq got=%b exp=0", mbreq); end
    checks++; if (mwdata !== 1'b0)  begin errors++; $display("FAIL arst_mwdata got=%b exp=0", mwdata); end
    checks++; if (mmode !== 1'b0)   begin errors++; $display("FAIL arst_mmode got=%b exp=0", mmode); end
    checks++; if (drdata !== 8'h00) begin errors++; $display("FAIL arst_drdata got=%h exp=00", drdata); end
    checks++; if (dready !== 1'b1)  begin errors++; $display("FAIL arst_dready got=%b exp=1", dready); end
    #2 rstn = 1'b1;
    tick();
    checks++; if (mvalid !== 1'b0 || dready !== 1'b1 || drvalid !== 1'b0) begin errors++; $display("FAIL post_rst got mvalid=%b dready=%b drvalid=%b exp 0 1 0", mvalid, dready, drvalid); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_gaps();
    test_split();
    test_timeout();
    test_ignored_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
